// File: rtl/usb_rx_sequencer.sv
// Receive-side USB SIE sequencer: SYNC hunt, bit unstuffing, LSB-first byte assembly, EOP/error detection.
// Define RX_BYTE_COUNT_EN to build the per-packet byte counter; otherwise rx_byte_count is tied to zero.
module usb_rx_sequencer #(
    parameter int SYNC_ZEROS = 6,
    parameter int STUFF_LEN  = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_strobe,
    input  logic       rx_bit,
    input  logic       rx_se0,
    output logic       en_nrzidecoder,
    output logic       en_bitunstuff,
    output logic       en_sipo,
    output logic       rx_active,
    output logic [7:0] rx_byte,
    output logic       rx_byte_valid,
    output logic       rx_eop,
    output logic       rx_err,
    output logic [9:0] rx_byte_count
);

    // state | meaning
    // RESET | held in reset, everything disabled
    // IDLE  | hunting for SYNC
    // DATA  | unstuffing and assembling bytes
    // EOP   | counting SE0 bit times of the end-of-packet
    // ERR   | waiting for SE0 followed by J before hunting again
    localparam logic [2:0] S_RESET = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_EOP   = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    localparam int ZW = $clog2(SYNC_ZEROS + 1);

    logic [2:0]    state, state_n;
    logic [ZW-1:0] zero_cnt, zero_n;
    logic [2:0]    ones_cnt, ones_n;
    logic [2:0]    bit_cnt, bit_n;
    logic [1:0]    se0_cnt, se0_n;
    logic          se0_seen, seen_n;
    logic [6:0]    shift, shift_n;
    logic [7:0]    byte_n;
    logic          valid_n, eop_n, err_n;

    always_comb begin
        state_n = state;
        zero_n  = zero_cnt;
        ones_n  = ones_cnt;
        bit_n   = bit_cnt;
        se0_n   = se0_cnt;
        seen_n  = se0_seen;
        shift_n = shift;
        byte_n  = rx_byte;
        valid_n = 1'b0;
        eop_n   = 1'b0;
        err_n   = 1'b0;
        case (state)
            S_RESET: state_n = S_IDLE;
            S_IDLE: begin
                if (rx_strobe) begin
                    if (rx_se0) begin
                        zero_n = '0;
                    end else if (!rx_bit) begin
                        if (zero_cnt != ZW'(SYNC_ZEROS))
                            zero_n = zero_cnt + 1'b1;
                    end else if (zero_cnt >= ZW'(SYNC_ZEROS)) begin
                        state_n = S_DATA;
                        zero_n  = '0;
                        ones_n  = 3'd1;
                        bit_n   = 3'd0;
                    end else begin
                        zero_n = '0;
                    end
                end
            end
            S_DATA: begin
                if (rx_strobe) begin
                    if (rx_se0) begin
                        if (bit_cnt != 3'd0) begin
                            // this SE0 already counts toward the recovery SE0
                            err_n   = 1'b1;
                            state_n = S_ERR;
                            seen_n  = 1'b1;
                        end else begin
                            state_n = S_EOP;
                            se0_n   = 2'd1;
                        end
                    end else if (ones_cnt == 3'(STUFF_LEN)) begin
                        if (!rx_bit) begin
                            ones_n = 3'd0;
                        end else begin
                            err_n   = 1'b1;
                            state_n = S_ERR;
                            seen_n  = 1'b0;
                        end
                    end else begin
                        shift_n = {rx_bit, shift[6:1]};
                        bit_n   = bit_cnt + 3'd1;
                        ones_n  = rx_bit ? ones_cnt + 3'd1 : 3'd0;
                        if (bit_cnt == 3'd7) begin
                            byte_n  = {rx_bit, shift};
                            valid_n = 1'b1;
                        end
                    end
                end
            end
            S_EOP: begin
                if (rx_strobe) begin
                    if (rx_se0) begin
                        if (se0_cnt != 2'd3)
                            se0_n = se0_cnt + 2'd1;
                    end else if (se0_cnt >= 2'd2) begin
                        eop_n   = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        err_n   = 1'b1;
                        state_n = S_ERR;
                        seen_n  = 1'b0;
                    end
                end
            end
            S_ERR: begin
                if (rx_strobe) begin
                    if (rx_se0)
                        seen_n = 1'b1;
                    else if (se0_seen)
                        state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (state_n == S_IDLE && state != S_IDLE) begin
            zero_n  = '0;
            ones_n  = 3'd0;
            bit_n   = 3'd0;
            se0_n   = 2'd0;
            seen_n  = 1'b0;
            shift_n = 7'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_RESET;
            zero_cnt       <= '0;
            ones_cnt       <= 3'd0;
            bit_cnt        <= 3'd0;
            se0_cnt        <= 2'd0;
            se0_seen       <= 1'b0;
            shift          <= 7'd0;
            rx_byte        <= 8'h00;
            rx_byte_valid  <= 1'b0;
            rx_eop         <= 1'b0;
            rx_err         <= 1'b0;
            en_nrzidecoder <= 1'b0;
            en_bitunstuff  <= 1'b0;
            en_sipo        <= 1'b0;
            rx_active      <= 1'b0;
        end else begin
            state          <= state_n;
            zero_cnt       <= zero_n;
            ones_cnt       <= ones_n;
            bit_cnt        <= bit_n;
            se0_cnt        <= se0_n;
            se0_seen       <= seen_n;
            shift          <= shift_n;
            rx_byte        <= byte_n;
            rx_byte_valid  <= valid_n;
            rx_eop         <= eop_n;
            rx_err         <= err_n;
            en_nrzidecoder <= (state_n != S_RESET);
            en_bitunstuff  <= (state_n == S_DATA);
            en_sipo        <= (state_n == S_DATA);
            rx_active      <= (state_n == S_DATA) || (state_n == S_EOP);
        end
    end

`ifdef RX_BYTE_COUNT_EN
    // count survives EOP so it can be read after the packet; cleared by the next SYNC
    logic [9:0] byte_count;
    logic       count_clr;

    assign count_clr = (state == S_IDLE) && (state_n == S_DATA);

    always_ff @(posedge clk) begin
        if (rst)
            byte_count <= 10'd0;
        else if (count_clr)
            byte_count <= 10'd0;
        else if (valid_n && byte_count != 10'd1023)
            byte_count <= byte_count + 10'd1;
    end

    assign rx_byte_count = byte_count;
`else
    assign rx_byte_count = 10'd0;
`endif

endmodule
